// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the BRAM delay-line sequencer.
// Holds the FSM state encoding and the modular read-address helper.
package delay_line_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    DLC_IDLE = 2'd0,
    DLC_FILL = 2'd1,
    DLC_RUN  = 2'd2
  } dlc_state_e;

  // wr < depth and 1 <= dly <= depth, so one conditional subtract wraps it
  function automatic int unsigned rd_addr_calc(
    input int unsigned wr,
    input int unsigned dly,
    input int unsigned depth
  );
    int unsigned s;
    s = wr + depth - dly;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Wrapping modulo-DEPTH pointer with increment and clear.
// Clear wins over increment.
module ring_ptr #(
  parameter int DEPTH = 32,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = (ptr_q == W'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// Programmable-delay sequencer for a read-before-write BRAM delay line.
// DELAY_LINE_CTRL_OCCUPANCY_EN adds occupancy_o and sticky underrun_o.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int RAM_DEPTH     = 32,
  parameter int ADDR_WIDTH    = $clog2(RAM_DEPTH),
  parameter int DLY_WIDTH     = ADDR_WIDTH + 1,
  parameter int DEFAULT_DELAY = RAM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [DLY_WIDTH-1:0]  delay_i,
  input  logic                  delay_load_i,
  input  logic                  in_valid_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  out_valid_o,
  output logic [STATE_W-1:0]    state_o,
  output logic                  cfg_err_o
`ifdef DELAY_LINE_CTRL_OCCUPANCY_EN
  ,
  output logic [DLY_WIDTH-1:0]  occupancy_o,
  output logic                  underrun_o
`endif
);

  dlc_state_e            state_q;
  logic [DLY_WIDTH-1:0]  delay_q;
  logic [DLY_WIDTH-1:0]  fill_q;
  logic                  out_valid_q;
  logic                  cfg_err_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic accept, rd_en, go_idle, load_ok, load_bad, dly_ok;

  assign go_idle  = flush_i | ~enable_i;
  assign accept   = in_valid_i & (state_q != DLC_IDLE);
  assign rd_en    = accept & (state_q == DLC_RUN);
  assign dly_ok   = (delay_i != '0) &&
                    (delay_i <= DLY_WIDTH'(RAM_DEPTH));
  assign load_ok  = delay_load_i & dly_ok;
  assign load_bad = delay_load_i & ~dly_ok;

  ring_ptr #(
    .DEPTH (RAM_DEPTH),
    .W     (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (accept),
    .clr_i  (go_idle),
    .ptr_o  (wr_ptr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DLC_IDLE;
      delay_q     <= DLY_WIDTH'(DEFAULT_DELAY);
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q   <= load_bad;
      out_valid_q <= rd_en & ~load_ok & ~go_idle;
      if (load_ok) delay_q <= delay_i;
      if (go_idle) begin
        state_q <= DLC_IDLE;
        fill_q  <= '0;
      end else begin
        if (load_ok) fill_q <= '0;
        unique case (state_q)
          DLC_IDLE: state_q <= DLC_FILL;
          DLC_FILL: begin
            // Accept in the load cycle still uses the old delay
            if (!load_ok && accept) begin
              if (fill_q == delay_q - 1'b1) state_q <= DLC_RUN;
              if (fill_q != delay_q) fill_q <= fill_q + 1'b1;
            end
          end
          DLC_RUN:  if (load_ok) state_q <= DLC_FILL;
          default:  state_q <= DLC_IDLE;
        endcase
      end
    end
  end

  assign wr_en_o     = accept;
  assign wr_addr_o   = wr_ptr;
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = ADDR_WIDTH'(rd_addr_calc(
                         32'(wr_ptr), 32'(delay_q), RAM_DEPTH));
  assign out_valid_o = out_valid_q;
  assign state_o     = state_q;
  assign cfg_err_o   = cfg_err_q;

`ifdef DELAY_LINE_CTRL_OCCUPANCY_EN
  logic underrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      underrun_q <= 1'b0;
    else if (go_idle || state_q == DLC_IDLE)
      underrun_q <= 1'b0;
    else if (state_q == DLC_RUN && !in_valid_i)
      underrun_q <= 1'b1;
  end

  always_comb begin
    occupancy_o = '0;
    unique case (1'b1)
      state_q == DLC_FILL: occupancy_o = fill_q;
      state_q == DLC_RUN:  occupancy_o = delay_q;
      default:             occupancy_o = '0;
    endcase
  end

  assign underrun_o = underrun_q;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl with a behavioural BRAM.
// Expected samples are queued at read time and popped on out_valid_o.
module tb_delay_line_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 6;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic          flush_i;
  logic [DW-1:0] delay_i;
  logic          delay_load_i;
  logic          in_valid_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          out_valid_o;
  logic [1:0]    state_o;
  logic          cfg_err_o;

  always #5 clk = ~clk;

  delay_line_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .delay_i      (delay_i),
    .delay_load_i (delay_load_i),
    .in_valid_i   (in_valid_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .out_valid_o  (out_valid_o),
    .state_o      (state_o),
    .cfg_err_o    (cfg_err_o)
  );

  // read-before-write BRAM with registered read
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] mem [DEPTH];

  always @(posedge clk) begin
    if (rd_en_o) dout <= mem[rd_addr_o];
    if (wr_en_o) mem[wr_addr_o] <= din;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int          m_state, m_ptr, m_fill, m_dly;
  bit          m_ov, m_err;
  logic [15:0] seq;
  logic [15:0] hist [$];
  logic [15:0] exp_q [$];

  task automatic cyc(input bit v, input bit en = 1'b1,
                     input bit fl = 1'b0, input bit ld = 1'b0,
                     input int d = 0);
    bit acc, rd, legal, idle;
    enable_i     = en;
    flush_i      = fl;
    delay_load_i = ld;
    delay_i      = DW'(d);
    in_valid_i   = v;
    din          = seq;
    #1;
    acc = v && (m_state != 0);
    rd  = acc && (m_state == 2);
    check("wr_en", 32'(wr_en_o), 32'(acc));
    check("rd_en", 32'(rd_en_o), 32'(rd));
    if (acc) begin
      check("wr_addr", 32'(wr_addr_o), m_ptr);
      check("rd_addr", 32'(rd_addr_o),
            (m_ptr + DEPTH - m_dly) % DEPTH);
    end
    legal = ld && d >= 1 && d <= DEPTH;
    idle  = fl || !en;
    m_err = ld && !legal;
    m_ov  = rd && !legal && !idle;
    if (m_ov) exp_q.push_back(hist[hist.size() - m_dly]);
    if (acc) begin
      hist.push_back(seq);
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    if (legal) m_dly = d;
    if (idle) begin
      m_state = 0;
      m_ptr   = 0;
      m_fill  = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (legal) m_fill = 0;
          else if (acc) begin
            if (m_fill == m_dly - 1) m_state = 2;
            if (m_fill < m_dly) m_fill++;
          end
        end
        default: begin
          if (legal) begin
            m_fill  = 0;
            m_state = 1;
          end
        end
      endcase
    end
    seq++;
    @(negedge clk);
    check("state", 32'(state_o), m_state);
    check("out_valid", 32'(out_valid_o), 32'(m_ov));
    check("cfg_err", 32'(cfg_err_o), 32'(m_err));
    if (m_ov && exp_q.size() > 0)
      check("data", 32'(dout), 32'(exp_q.pop_front()));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_ov"}, 32'(out_valid_o), 0);
    check({tag, "_wr_en"}, 32'(wr_en_o), 0);
    check({tag, "_rd_en"}, 32'(rd_en_o), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr_o), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr_o), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err_o), 0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    enable_i     = 1'b0;
    flush_i      = 1'b0;
    delay_i      = '0;
    delay_load_i = 1'b0;
    in_valid_i   = 1'b0;
    din          = '0;
    seq          = '0;
    m_state = 0; m_ptr = 0; m_fill = 0; m_dly = DEPTH;
    m_ov = 1'b0; m_err = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    // default delay 32: rd_addr tracks wr_addr
    repeat (80) cyc(1'b1);

    // flush, then load 5 while idle
    cyc(1'b0, 1'b1, 1'b1);
    check("flush_wr_addr", 32'(wr_addr_o), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5);
    repeat (70) cyc(1'b1);

    // delay 8 with random stalls
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8);
    repeat (150) cyc(1'($urandom_range(0, 1)));

    // reconfigure in RUN
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3);
    repeat (40) cyc(1'b1);

    // illegal loads leave the stream alone
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 33);
    repeat (20) cyc(1'b1);

    // delay of 1
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1);
    repeat (12) cyc(1'b1);

    // flush with a simultaneous legal load
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 6);
    check("flush2_wr_addr", 32'(wr_addr_o), 0);
    repeat (30) cyc(1'b1);

    // enable drop mid-stream
    cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b1);

    // back to delay 1, then async reset between edges
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1);
    repeat (6) cyc(1'b1);
    check("pre_rst_ov", 32'(out_valid_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_zero("async_rst");
    m_state = 0; m_ptr = 0; m_fill = 0; m_dly = DEPTH;
    m_ov = 1'b0; m_err = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (40) cyc(1'b1);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
